// File: rtl/rpc_pkg.sv
// ============================================================================
// Module      : rpc_pkg
// Description : Shared constants for the RPC bus sequencer: state encoding,
//               command decode and default data width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rpc_pkg;

  localparam int c_data_w = 16;

  localparam logic [2:0] c_cmd_nop  = 3'h0;
  localparam int         c_read_bit = 1;

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_w_setup  = 3'd1;
  localparam logic [2:0] c_st_w_strobe = 3'd2;
  localparam logic [2:0] c_st_r_wait   = 3'd3;
  localparam logic [2:0] c_st_turn     = 3'd4;

  function automatic logic cmd_is_read(input logic [2:0] cmd);
    return cmd[c_read_bit];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rpc_rr_arbiter.sv
// ============================================================================
// Module      : rpc_rr_arbiter
// Description : Two-way round-robin arbiter; the last-grant pointer moves
//               only when a grant is actually accepted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpc_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  output logic       grant_id,
  output logic       accept
);

  logic r_last;
  logic w_gid;

  // With no requester valid, the ready bit parks on the one due next.
  always_comb begin
    w_gid = ~r_last;
    if (req_valid == 2'b01)
      w_gid = 1'b0;
    else if (req_valid == 2'b10)
      w_gid = 1'b1;
  end

  assign req_ready = en ? (w_gid ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign grant_id  = w_gid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_last <= 1'b1;
    else if (accept)
      r_last <= w_gid;
  end

endmodule

`default_nettype wire

// File: rtl/rpc_bus_sequencer.sv
// ============================================================================
// Module      : rpc_bus_sequencer
// Description : Sequences write/read/NOP transactions on the shared RPC bus
//               for two round-robin requesters. Read timeout is enabled by
//               defining RPC_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpc_bus_sequencer
  import rpc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int DATA_W      = c_data_w
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2:0]        req_cmd0,
  input  logic [2:0]        req_cmd1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [2:0]        rpc_cmd,
  inout  wire  [DATA_W-1:0] rpc_data,
  inout  wire               rpc_data_valid
);

  logic [2:0]        r_state;
  logic [2:0]        r_rpc_cmd;
  logic              r_drv_en;
  logic              r_strobe_out;
  logic              r_id;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic              r_rsp_timeout;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_idle;
  logic              w_accept;
  logic              w_gid;
  logic              w_strobe_in;
  logic [2:0]        w_cmd;
  logic [DATA_W-1:0] w_wdata;

`ifdef RPC_SEQ_TIMEOUT_EN
  localparam int c_cnt_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_expired;
  assign w_expired = (r_cnt == c_cnt_w'(TIMEOUT_CYC - 1));
`endif

  assign w_idle = (r_state == c_st_idle);

  rpc_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (w_idle),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .grant_id  (w_gid),
    .accept    (w_accept)
  );

  assign w_cmd       = w_gid ? req_cmd1   : req_cmd0;
  assign w_wdata     = w_gid ? req_wdata1 : req_wdata0;
  assign w_strobe_in = (rpc_data_valid == 1'b1);

  assign rpc_data       = r_drv_en ? r_wdata      : {DATA_W{1'bz}};
  assign rpc_data_valid = r_drv_en ? r_strobe_out : 1'bz;

  assign rpc_cmd     = r_rpc_cmd;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= c_st_idle;
      r_rpc_cmd     <= c_cmd_nop;
      r_drv_en      <= 1'b0;
      r_strobe_out  <= 1'b0;
      r_id          <= 1'b0;
      r_wdata       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
`ifdef RPC_SEQ_TIMEOUT_EN
      r_cnt         <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_id <= w_gid;
            if (w_cmd == c_cmd_nop) begin
              r_state       <= c_st_turn;
              r_rsp_valid   <= 1'b1;
              r_rsp_id      <= w_gid;
              r_rsp_rdata   <= '0;
              r_rsp_timeout <= 1'b0;
            end else if (cmd_is_read(w_cmd)) begin
              r_state   <= c_st_r_wait;
              r_rpc_cmd <= w_cmd;
`ifdef RPC_SEQ_TIMEOUT_EN
              r_cnt     <= '0;
`endif
            end else begin
              r_state      <= c_st_w_setup;
              r_rpc_cmd    <= w_cmd;
              r_wdata      <= w_wdata;
              r_drv_en     <= 1'b1;
              r_strobe_out <= 1'b0;
            end
          end
        end
        c_st_w_setup: begin
          r_state      <= c_st_w_strobe;
          r_strobe_out <= 1'b1;
        end
        c_st_w_strobe: begin
          r_state       <= c_st_turn;
          r_rpc_cmd     <= c_cmd_nop;
          r_drv_en      <= 1'b0;
          r_strobe_out  <= 1'b0;
          r_rsp_valid   <= 1'b1;
          r_rsp_id      <= r_id;
          r_rsp_rdata   <= '0;
          r_rsp_timeout <= 1'b0;
        end
        c_st_r_wait: begin
          // A strobe in the expiry cycle still counts as a completed read.
          if (w_strobe_in) begin
            r_state       <= c_st_turn;
            r_rpc_cmd     <= c_cmd_nop;
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_id;
            r_rsp_rdata   <= rpc_data;
            r_rsp_timeout <= 1'b0;
          end
`ifdef RPC_SEQ_TIMEOUT_EN
          else if (w_expired) begin
            r_state       <= c_st_turn;
            r_rpc_cmd     <= c_cmd_nop;
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_id;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        c_st_turn: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state   <= c_st_idle;
          r_rpc_cmd <= c_cmd_nop;
          r_drv_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rpc_bus_sequencer.sv
// ============================================================================
// Module      : tb_rpc_bus_sequencer
// Description : Directed bench for rpc_bus_sequencer with a cycle-offset
//               transaction model and per-cycle output comparison.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rpc_bus_sequencer;

  localparam int TIMEOUT_CYC = 8;
  localparam int DATA_W      = 16;
`ifdef RPC_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        req_valid = 2'b00;
  logic [1:0]        req_ready;
  logic [2:0]        req_cmd0 = 3'h0, req_cmd1 = 3'h0;
  logic [DATA_W-1:0] req_wdata0 = '0, req_wdata1 = '0;
  logic              rsp_valid, rsp_id, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic [2:0]        rpc_cmd;
  wire  [DATA_W-1:0] rpc_data;
  wire               rpc_data_valid;

  // Bench side of the bus: plays the front-end (and its pull-down) whenever
  // the controller is supposed to be released.
  logic [DATA_W-1:0] tb_data_val   = 16'h5A5A;
  logic              tb_strobe_val = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Transaction model: offset m_t counts cycles since acceptance.
  logic              m_active = 1'b0, m_last = 1'b1, m_id = 1'b0, m_to = 1'b0;
  int                m_t = 0, m_rsp_t = 0, m_kind = 0;   // kind: 0 nop, 1 write, 2 read
  logic [2:0]        m_cmd = 3'h0;
  logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0;
  logic              m_g, m_drv;
  logic [2:0]        m_new_cmd;

  int   acc_cyc_q[$];
  bit   acc_id_q[$];
  int   rsp_cyc_q[$];
  bit   rsp_id_q[$];
  bit   rsp_to_q[$];
  logic [DATA_W-1:0] rsp_data_q[$];

  rpc_bus_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd0       (req_cmd0),
    .req_cmd1       (req_cmd1),
    .req_wdata0     (req_wdata0),
    .req_wdata1     (req_wdata1),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_rdata      (rsp_rdata),
    .rsp_timeout    (rsp_timeout),
    .rpc_cmd        (rpc_cmd),
    .rpc_data       (rpc_data),
    .rpc_data_valid (rpc_data_valid)
  );

  initial forever #5 clk = ~clk;

  assign m_g       = (req_valid == 2'b01) ? 1'b0 : (req_valid == 2'b10) ? 1'b1 : ~m_last;
  assign m_new_cmd = m_g ? req_cmd1 : req_cmd0;
  assign m_drv     = m_active && (m_kind == 1) && (m_t != m_rsp_t);

  assign rpc_data       = m_drv ? {DATA_W{1'bz}} : tb_data_val;
  assign rpc_data_valid = m_drv ? 1'bz : tb_strobe_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_last   <= 1'b1;
      m_t      <= 0;
      m_rsp_t  <= 0;
      m_kind   <= 0;
      m_to     <= 1'b0;
      m_rdata  <= '0;
    end else if (!m_active) begin
      if (req_valid[m_g]) begin
        m_active <= 1'b1;
        m_last   <= m_g;
        m_id     <= m_g;
        m_t      <= 1;
        m_to     <= 1'b0;
        m_rdata  <= '0;
        m_cmd    <= m_new_cmd;
        m_wdata  <= m_g ? req_wdata1 : req_wdata0;
        if (m_new_cmd == 3'h0) begin
          m_kind <= 0; m_rsp_t <= 1;
        end else if (m_new_cmd[1]) begin
          m_kind <= 2; m_rsp_t <= 0;
        end else begin
          m_kind <= 1; m_rsp_t <= 3;
        end
        acc_cyc_q.push_back(cyc);
        acc_id_q.push_back(m_g);
      end
    end else if (m_t == m_rsp_t) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if (m_kind == 2 && m_rsp_t == 0) begin
        if (rpc_data_valid === 1'b1) begin
          m_rsp_t <= m_t + 1;
          m_rdata <= rpc_data;
        end else if (TO_EN && m_t == TIMEOUT_CYC) begin
          m_rsp_t <= m_t + 1;
          m_to    <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!m_active) begin
        chk("ready_idle", {30'd0, req_ready}, m_g ? 32'd2 : 32'd1);
        chk("cmd_idle", {29'd0, rpc_cmd}, 32'd0);
        chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
      end else if (m_t == m_rsp_t) begin
        chk("ready_busy", {30'd0, req_ready}, 32'd0);
        chk("cmd_turn", {29'd0, rpc_cmd}, 32'd0);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
        chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, m_rdata});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, m_to});
      end else begin
        chk("ready_busy", {30'd0, req_ready}, 32'd0);
        chk("cmd_active", {29'd0, rpc_cmd}, {29'd0, m_cmd});
        chk("rsp_valid_busy", {31'd0, rsp_valid}, 32'd0);
      end
      if (m_drv) begin
        chk("bus_wdata", {16'd0, rpc_data}, {16'd0, m_wdata});
        chk("bus_strobe", {31'd0, rpc_data_valid}, (m_t == 2) ? 32'd1 : 32'd0);
      end else begin
        chk("bus_released_data", {16'd0, rpc_data}, {16'd0, tb_data_val});
        chk("bus_released_strobe", {31'd0, rpc_data_valid}, {31'd0, tb_strobe_val});
      end
      if (rsp_valid === 1'b1) begin
        rsp_cyc_q.push_back(cyc);
        rsp_id_q.push_back(rsp_id);
        rsp_to_q.push_back(rsp_timeout);
        rsp_data_q.push_back(rsp_rdata);
      end
    end
  end

  task automatic request(input int id, input logic [2:0] cmd, input logic [DATA_W-1:0] wd);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    if (id == 0) begin req_cmd0 = cmd; req_wdata0 = wd; end
    else         begin req_cmd1 = cmd; req_wdata1 = wd; end
    req_valid[id] = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (!ok) chk("accept_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!m_active) break;
    end
    if (m_active) chk("idle_wait", 32'd0, 32'd1);
  endtask

  function automatic int last_rsp_lat();
    return rsp_cyc_q[rsp_cyc_q.size()-1] - acc_cyc_q[acc_cyc_q.size()-1];
  endfunction

  initial begin
    int n0, nr, cs, last;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, nr, cs, li;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", {29'd0, rpc_cmd}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Write from requester 0
    request(0, 3'h1, 16'h1234);
    @(negedge clk);
    chk("wr_k1_data", {16'd0, rpc_data}, 32'h1234);
    chk("wr_k1_strobe", {31'd0, rpc_data_valid}, 32'd0);
    @(negedge clk);
    chk("wr_k2_data", {16'd0, rpc_data}, 32'h1234);
    chk("wr_k2_strobe", {31'd0, rpc_data_valid}, 32'd1);
    @(negedge clk);
    chk("wr_k3_rsp", {31'd0, rsp_valid}, 32'd1);
    wait_idle();
    li = rsp_id_q.size() - 1;
    chk("wr_rsp_id", {31'd0, rsp_id_q[li]}, 32'd0);
    chk("wr_rsp_rdata", {16'd0, rsp_data_q[li]}, 32'd0);
    chk("wr_latency", last_rsp_lat(), 32'd3);

    // NOP from requester 0
    request(0, 3'h0, 16'hFFFF);
    @(negedge clk);
    chk("nop_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("nop_cmd", {29'd0, rpc_cmd}, 32'd0);
    wait_idle();
    chk("nop_latency", last_rsp_lat(), 32'd1);

    // Read from requester 1, strobe a few cycles later
    request(1, 3'h3, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    cs = cyc;
    tb_data_val   = 16'hBEEF;
    tb_strobe_val = 1'b1;
    @(posedge clk); #1;
    tb_strobe_val = 1'b0;
    tb_data_val   = 16'h5A5A;
    wait_idle();
    li = rsp_id_q.size() - 1;
    chk("rd_rsp_cycle", rsp_cyc_q[li], cs + 1);
    chk("rd_rsp_rdata", {16'd0, rsp_data_q[li]}, 32'hBEEF);
    chk("rd_rsp_id", {31'd0, rsp_id_q[li]}, 32'd1);
    chk("rd_rsp_timeout", {31'd0, rsp_to_q[li]}, 32'd0);

    // Both requesters writing continuously
    @(posedge clk); #1;
    req_cmd0 = 3'h1; req_wdata0 = 16'hAAAA;
    req_cmd1 = 3'h5; req_wdata1 = 16'h5555;
    n0 = acc_cyc_q.size();
    req_valid = 2'b11;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (acc_cyc_q.size() >= n0 + 4) break;
    end
    #1;
    req_valid = 2'b00;
    wait_idle();
    if (acc_cyc_q.size() < n0 + 4) begin
      chk("rr_accepts", acc_cyc_q.size() - n0, 32'd4);
    end else begin
      for (int i = 0; i < 4; i++)
        chk("rr_grant_order", {31'd0, acc_id_q[n0+i]}, (i % 2 == 0) ? 32'd0 : 32'd1);
      for (int i = 0; i < 3; i++)
        chk("rr_spacing", acc_cyc_q[n0+i+1] - acc_cyc_q[n0+i], 32'd4);
    end

`ifdef RPC_SEQ_TIMEOUT_EN
    // Read with no strobe
    request(1, 3'h2, 16'h0000);
    wait_idle();
    li = rsp_id_q.size() - 1;
    chk("to_flag", {31'd0, rsp_to_q[li]}, 32'd1);
    chk("to_rdata", {16'd0, rsp_data_q[li]}, 32'd0);
    chk("to_latency", last_rsp_lat(), 32'd9);
`endif

    // Reset during the strobe cycle of a write
    request(1, 3'h4, 16'hC0DE);
    nr = rsp_cyc_q.size();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_cmd", {29'd0, rpc_cmd}, 32'd0);
    chk("arst_data_released", {16'd0, rpc_data}, 32'h5A5A);
    chk("arst_strobe_released", {31'd0, rpc_data_valid}, 32'd0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("arst_no_rsp", rsp_cyc_q.size(), nr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
